// File: rtl/jtcps1_obj_pkg.sv
// Shared definitions for the CPS1 per-line object scheduler: FSM states,
// object table word offsets, end-of-table marker and attribute field positions.
package jtcps1_obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } obj_state_t;

    localparam logic [1:0] WD_X    = 2'd0;
    localparam logic [1:0] WD_Y    = 2'd1;
    localparam logic [1:0] WD_CODE = 2'd2;
    localparam logic [1:0] WD_ATTR = 2'd3;

    localparam logic [7:0] END_MARK = 8'hFF;

    localparam int ATTR_VSIZE_LSB = 12;
    localparam int ATTR_HSIZE_LSB = 8;
    localparam int ATTR_VFLIP     = 6;
    localparam int ATTR_HFLIP     = 5;

endpackage

// File: rtl/jtcps1_obj_sched.sv
// Per-line object scheduler: scans the object table, expands hit objects into
// 16-px tiles and hands them to the draw engine. Optional macro: JTCPS1_OBJ_LIMIT_EN.
module jtcps1_obj_sched
    import jtcps1_obj_pkg::*;
#(
    parameter int OBJ_MAX    = 256,
    parameter int AW         = 10,
    parameter int TILE_LIMIT = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          line_start,
    input  logic [8:0]    vrender,
    output logic [AW-1:0] tbl_addr,
    input  logic [15:0]   tbl_data,
    output logic          dr_start,
    output logic [15:0]   dr_code,
    output logic [15:0]   dr_attr,
    output logic [8:0]    dr_hpos,
    input  logic          dr_idle,
    output logic          busy,
    output logic          line_done,
    output logic          overflow
);

    localparam int EW = AW - 2;

    obj_state_t      r_state, w_next;
    logic [EW-1:0]   r_entry;
    logic [2:0]      r_wcnt;
    logic [8:0]      r_x, r_y, r_vrender;
    logic [15:0]     r_code, r_attr;
    logic [3:0]      r_col, r_row, r_vsub;
    logic            r_start, r_busy, r_done;
    logic [15:0]     r_dr_code, r_dr_attr;
    logic [8:0]      r_dr_hpos;

    logic [3:0]      w_vsize, w_hsize, w_tile_col, w_row_raw;
    logic [8:0]      w_dy, w_span;
    logic            w_hit, w_last_entry, w_last_tile, w_endmark, w_limit;

    assign w_vsize      = r_attr[ATTR_VSIZE_LSB +: 4];
    assign w_hsize      = r_attr[ATTR_HSIZE_LSB +: 4];
    assign w_dy         = r_vrender - r_y;
    assign w_span       = {({1'b0, w_vsize} + 5'd1), 4'b0000};
    assign w_hit        = (w_dy < w_span);
    assign w_row_raw    = w_dy[7:4];
    assign w_last_entry = (r_entry == EW'(OBJ_MAX - 1));
    assign w_last_tile  = (r_col == w_hsize);
    assign w_endmark    = (tbl_data[15:8] == END_MARK);
    assign w_tile_col   = r_attr[ATTR_HFLIP] ? (w_hsize - r_col) : r_col;

`ifdef JTCPS1_OBJ_LIMIT_EN
    localparam int TW = $clog2(TILE_LIMIT + 1);
    logic [TW-1:0] r_tcnt;
    logic          r_overflow;
    assign w_limit  = (r_tcnt == TW'(TILE_LIMIT));
    assign overflow = r_overflow;
`else
    assign w_limit  = 1'b0;
    assign overflow = 1'b0;
`endif

    // word counter doubles as the low address bits; count 4 is the capture-only cycle
    assign tbl_addr  = {r_entry, r_wcnt[1:0]};
    assign dr_start  = r_start;
    assign dr_code   = r_dr_code;
    assign dr_attr   = r_dr_attr;
    assign dr_hpos   = r_dr_hpos;
    assign busy      = r_busy;
    assign line_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_FETCH: if (r_wcnt == 3'd4) w_next = w_endmark ? ST_DONE : ST_CHECK;
            ST_CHECK: begin
                if (w_hit)             w_next = ST_ISSUE;
                else if (w_last_entry) w_next = ST_DONE;
                else                   w_next = ST_FETCH;
            end
            ST_ISSUE: begin
                if (w_limit)      w_next = ST_DONE;
                else if (dr_idle) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (!w_last_tile)      w_next = ST_ISSUE;
                else if (w_last_entry) w_next = ST_DONE;
                else                   w_next = ST_FETCH;
            end
            ST_DONE:  if (dr_idle) w_next = ST_IDLE;
            default:  w_next = r_state;
        endcase
        if (line_start) w_next = ST_FETCH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry   <= '0;
            r_wcnt    <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_vrender <= '0;
            r_code    <= '0;
            r_attr    <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_vsub    <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dr_code <= '0;
            r_dr_attr <= '0;
            r_dr_hpos <= '0;
`ifdef JTCPS1_OBJ_LIMIT_EN
            r_tcnt     <= '0;
            r_overflow <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            r_done  <= 1'b0;
            if (line_start) begin
                r_entry   <= '0;
                r_wcnt    <= '0;
                r_vrender <= vrender;
                r_busy    <= 1'b1;
`ifdef JTCPS1_OBJ_LIMIT_EN
                r_tcnt     <= '0;
                r_overflow <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        r_wcnt <= (r_wcnt == 3'd4) ? 3'd0 : r_wcnt + 3'd1;
                        // table data lags the address by one cycle
                        case (r_wcnt)
                            3'd1:    r_x    <= tbl_data[8:0];
                            3'd2:    r_y    <= tbl_data[8:0];
                            3'd3:    r_code <= tbl_data;
                            3'd4:    r_attr <= tbl_data;
                            default: ;
                        endcase
                    end
                    ST_CHECK: begin
                        if (w_hit) begin
                            r_col  <= '0;
                            r_row  <= r_attr[ATTR_VFLIP] ? (w_vsize - w_row_raw) : w_row_raw;
                            r_vsub <= r_attr[ATTR_VFLIP] ? ~w_dy[3:0] : w_dy[3:0];
                        end else if (!w_last_entry) begin
                            r_entry <= r_entry + EW'(1);
                        end
                    end
                    ST_ISSUE: begin
                        if (w_limit) begin
`ifdef JTCPS1_OBJ_LIMIT_EN
                            r_overflow <= 1'b1;
`endif
                        end else if (dr_idle) begin
                            r_start   <= 1'b1;
                            r_dr_code <= {r_code[15:8], r_code[7:4] + r_row, r_code[3:0] + w_tile_col};
                            r_dr_attr <= {r_attr[15:12], r_vsub, r_attr[7:0]};
                            r_dr_hpos <= r_x + {1'b0, r_col, 4'b0000};
`ifdef JTCPS1_OBJ_LIMIT_EN
                            r_tcnt <= r_tcnt + TW'(1);
`endif
                        end
                    end
                    ST_WAIT: begin
                        if (!w_last_tile)       r_col   <= r_col + 4'd1;
                        else if (!w_last_entry) r_entry <= r_entry + EW'(1);
                    end
                    ST_DONE: begin
                        if (dr_idle) begin
                            r_done <= 1'b1;
                            r_busy <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
